// File: rtl/bus2st_pp.sv
`default_nettype none
// ============================================================================
//  Module   : bus2st_pp
//  Function : Ping-pong bus-word to Avalon-ST beat converter; packs bus words
//             into two packet buffers and unpacks a full one as ST beats.
//  Revision : 1.0 - initial release
// ============================================================================
module bus2st_pp #(
    parameter int BUS_W     = 512,
    parameter int ST_W      = 12,
    parameter int PKT_BEATS = 1028,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk_bus,
    input  logic              rst_n,
    input  logic [BUS_W-1:0]  bus_data,
    input  logic              bus_valid,
    input  logic              bus_err,
    output logic              bus_ready,
    input  logic              st_ready,
    output logic [ST_W-1:0]   st_data,
    output logic              st_valid,
    output logic              st_sop,
    output logic              st_eop,
    output logic              st_error,
    output logic [15:0]       pkt_cnt
);

    localparam int BEATS_PER_BUS = BUS_W / ST_W;
    localparam int BUS_PER_PKT   = (PKT_BEATS + BEATS_PER_BUS - 1) / BEATS_PER_BUS;
    localparam int USED_W        = BEATS_PER_BUS * ST_W;
    localparam int DEPTH         = 2 * BUS_PER_PKT;
    localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW            = (BUS_PER_PKT > 1) ? $clog2(BUS_PER_PKT) : 1;
    localparam int RW            = $clog2(BUS_PER_PKT + 1);
    localparam int BW            = (BEATS_PER_BUS > 1) ? $clog2(BEATS_PER_BUS) : 1;
    localparam int CW            = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_REL    = 2'd3
    } state_t;

    logic [USED_W-1:0] mem_q [DEPTH];

    logic [1:0]        full_q;
    logic [1:0]        err_q;
    logic              wr_buf_q;
    logic              rd_buf_q;
    logic [WW-1:0]     wr_word_q;
    logic [RW-1:0]     rd_word_q;
    logic [BW-1:0]     rd_beat_q;
    logic [CW-1:0]     bc_q;
    logic [USED_W-1:0] sh_q;
    logic [USED_W-1:0] pre_q;
    state_t            state_q;
    logic              st_valid_q;
    logic              st_sop_q;
    logic              st_eop_q;
    logic              st_error_q;
    logic [15:0]       pkt_cnt_q;

    logic              w_xfer;
    logic [AW-1:0]     w_wr_addr;
    logic [AW-1:0]     w_rd_base;
    logic [AW-1:0]     w_rd_addr1;
    logic [AW-1:0]     w_rd_addrn;
    logic [USED_W-1:0] w_sh_next;

    // Upper bus bits beyond the last whole beat carry no data.
    if (BUS_W > USED_W) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^bus_data[BUS_W-1:USED_W];
    end

    assign bus_ready = rst_n & ~full_q[wr_buf_q];
    assign w_xfer    = bus_valid & bus_ready;

    always_comb begin
        w_wr_addr  = (wr_buf_q ? AW'(BUS_PER_PKT) : '0) + AW'(wr_word_q);
        w_rd_base  = rd_buf_q ? AW'(BUS_PER_PKT) : '0;
        w_rd_addr1 = w_rd_base + AW'((BUS_PER_PKT > 1) ? 1 : 0);
        // Prefetch index saturates on the last word; excess fetches are never emitted.
        w_rd_addrn = w_rd_base + ((rd_word_q < RW'(BUS_PER_PKT)) ? AW'(rd_word_q)
                                                                  : AW'(BUS_PER_PKT - 1));
        w_sh_next  = MSB_FIRST ? (sh_q << ST_W) : (sh_q >> ST_W);
    end

    always_ff @(posedge clk_bus) begin
        if (w_xfer) begin
            mem_q[w_wr_addr] <= bus_data[USED_W-1:0];
        end
    end

    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            full_q     <= '0;
            err_q      <= '0;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b0;
            wr_word_q  <= '0;
            rd_word_q  <= '0;
            rd_beat_q  <= '0;
            bc_q       <= '0;
            sh_q       <= '0;
            pre_q      <= '0;
            state_q    <= S_IDLE;
            st_valid_q <= 1'b0;
            st_sop_q   <= 1'b0;
            st_eop_q   <= 1'b0;
            st_error_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            if (w_xfer) begin
                err_q[wr_buf_q] <= (wr_word_q == '0) ? bus_err : (err_q[wr_buf_q] | bus_err);
                if (wr_word_q == WW'(BUS_PER_PKT - 1)) begin
                    full_q[wr_buf_q] <= 1'b1;
                    wr_word_q        <= '0;
                    wr_buf_q         <= ~wr_buf_q;
                end else begin
                    wr_word_q <= wr_word_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (full_q[rd_buf_q]) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sh_q       <= mem_q[w_rd_base];
                    pre_q      <= mem_q[w_rd_addr1];
                    rd_word_q  <= RW'(2);
                    rd_beat_q  <= '0;
                    bc_q       <= '0;
                    st_valid_q <= 1'b1;
                    st_sop_q   <= 1'b1;
                    st_eop_q   <= (PKT_BEATS == 1);
                    st_error_q <= (PKT_BEATS == 1) & err_q[rd_buf_q];
                    state_q    <= S_STREAM;
                end
                S_STREAM: begin
                    if (st_ready) begin
                        st_sop_q <= 1'b0;
                        if (bc_q == CW'(PKT_BEATS - 1)) begin
                            st_valid_q <= 1'b0;
                            st_eop_q   <= 1'b0;
                            st_error_q <= 1'b0;
                            state_q    <= S_REL;
                        end else begin
                            bc_q       <= bc_q + 1'b1;
                            st_eop_q   <= (bc_q == CW'(PKT_BEATS - 2));
                            st_error_q <= (bc_q == CW'(PKT_BEATS - 2)) & err_q[rd_buf_q];
                            if (rd_beat_q == BW'(BEATS_PER_BUS - 1)) begin
                                sh_q      <= pre_q;
                                pre_q     <= mem_q[w_rd_addrn];
                                rd_beat_q <= '0;
                                if (rd_word_q < RW'(BUS_PER_PKT)) begin
                                    rd_word_q <= rd_word_q + 1'b1;
                                end
                            end else begin
                                sh_q      <= w_sh_next;
                                rd_beat_q <= rd_beat_q + 1'b1;
                            end
                        end
                    end
                end
                S_REL: begin
                    full_q[rd_buf_q] <= 1'b0;
                    rd_buf_q         <= ~rd_buf_q;
                    pkt_cnt_q        <= pkt_cnt_q + 16'd1;
                    state_q          <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign st_data  = MSB_FIRST ? sh_q[USED_W-1 -: ST_W] : sh_q[ST_W-1:0];
    assign st_valid = st_valid_q;
    assign st_sop   = st_sop_q;
    assign st_eop   = st_eop_q;
    assign st_error = st_error_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus2st_pp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus2st_pp
//  Function : Self-checking bench for bus2st_pp (LSB-first and MSB-first).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus2st_pp;

    localparam int BUS_W         = 512;
    localparam int ST_W          = 12;
    localparam int PKT_BEATS     = 1028;
    localparam int BEATS_PER_BUS = BUS_W / ST_W;
    localparam int BUS_PER_PKT   = (PKT_BEATS + BEATS_PER_BUS - 1) / BEATS_PER_BUS;
    localparam int USED_W        = BEATS_PER_BUS * ST_W;

    logic             clk_bus;
    logic             rst_n;
    logic [BUS_W-1:0] bus_data;
    logic             bus_valid;
    logic             bus_err;
    logic             st_ready;
    logic             bus_ready0, bus_ready1;
    logic [ST_W-1:0]  st_data0, st_data1;
    logic             st_valid0, st_valid1, st_sop0, st_sop1;
    logic             st_eop0, st_eop1, st_error0, st_error1;
    logic [15:0]      pkt_cnt0, pkt_cnt1;

    bus2st_pp #(.BUS_W(BUS_W), .ST_W(ST_W), .PKT_BEATS(PKT_BEATS), .MSB_FIRST(1'b0)) dut0 (
        .clk_bus(clk_bus), .rst_n(rst_n), .bus_data(bus_data), .bus_valid(bus_valid),
        .bus_err(bus_err), .bus_ready(bus_ready0), .st_ready(st_ready), .st_data(st_data0),
        .st_valid(st_valid0), .st_sop(st_sop0), .st_eop(st_eop0), .st_error(st_error0),
        .pkt_cnt(pkt_cnt0)
    );

    bus2st_pp #(.BUS_W(BUS_W), .ST_W(ST_W), .PKT_BEATS(PKT_BEATS), .MSB_FIRST(1'b1)) dut1 (
        .clk_bus(clk_bus), .rst_n(rst_n), .bus_data(bus_data), .bus_valid(bus_valid),
        .bus_err(bus_err), .bus_ready(bus_ready1), .st_ready(st_ready), .st_data(st_data1),
        .st_valid(st_valid1), .st_sop(st_sop1), .st_eop(st_eop1), .st_error(st_error1),
        .pkt_cnt(pkt_cnt1)
    );

    typedef struct {
        logic [ST_W-1:0] lsb;
        logic [ST_W-1:0] msb;
        logic            sop;
        logic            eop;
        logic            err;
        int              idx;
    } beat_t;

    typedef struct {
        int pkts;
        int ready_pct;
        int mode;
        int err_pkt;
        int err_word;
        bit bus_gaps;
        bit gap_chk;
        int exp_pkt_cnt;
        int exp_err_eops;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected beat stream and buffer occupancy.
    beat_t            exp_q[$];
    logic [BUS_W-1:0] words [BUS_PER_PKT];
    int               nwords    = 0;
    logic             pkt_err   = 1'b0;
    int               occ       = 0;
    bit               add_pend  = 1'b0;
    int               rel_dly   = 0;
    bit               in_pkt    = 1'b0;
    bit               stall     = 1'b0;
    logic [31:0]      snap;
    bit               have_eop  = 1'b0;
    int               gap       = 0;
    bit               fill_on   = 1'b0;
    int               fill_t    = 0;
    int               cur_beat  = -1;
    int               err_eops  = 0;
    bit               rst_prev  = 1'b1;
    bit               gap_chk   = 1'b0;
    bit               pat_chk   = 1'b0;
    int               ready_pct = 100;
    logic [ST_W-1:0]  first_lsb, first_msb;

    logic [31:0] w_outs;
    assign w_outs = {st_data0, st_data1, st_sop0, st_eop0, st_error0,
                     st_sop1, st_eop1, st_error1, st_valid0, st_valid1};

    initial begin
        clk_bus = 1'b0;
        forever #5 clk_bus = ~clk_bus;
    end

    initial begin
        st_ready = 1'b1;
        forever begin
            @(posedge clk_bus);
            #1;
            st_ready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clk_bus) begin : mon
        beat_t            e;
        logic [BUS_W-1:0] tw;
        logic [30:0]      got, expv;
        int               k;
        if (!rst_n) begin
            exp_q.delete();
            occ = 0; add_pend = 0; rel_dly = 0; nwords = 0; pkt_err = 0;
            in_pkt = 0; stall = 0; have_eop = 0; gap = 0; fill_on = 0; cur_beat = -1;
            if (!rst_prev) begin
                checks++;
                if ({bus_ready0, bus_ready1, st_valid0, st_valid1, st_sop0, st_sop1, st_eop0,
                     st_eop1, st_error0, st_error1, st_data0, st_data1, pkt_cnt0, pkt_cnt1} != '0)
                    begin
                    failures++;
                    $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b err=%b data=%h/%h cnt=%0d ready=%b, required all 0",
                             st_valid0, st_sop0, st_eop0, st_error0, st_data0, st_data1, pkt_cnt0, bus_ready0);
                end
            end
            rst_prev = 1'b0;
        end else begin
            rst_prev = 1'b1;
            if (rel_dly > 0) begin
                rel_dly--;
                if (rel_dly == 0) occ--;
            end
            if (add_pend) begin
                add_pend = 1'b0;
                occ++;
                if (occ == 1) begin fill_on = 1'b1; fill_t = 0; end
            end

            checks++;
            if (bus_ready0 !== (occ < 2) || bus_ready1 !== (occ < 2)) begin
                failures++;
                $display("FAIL bus_ready: got %b/%b required %b (buffers full=%0d)",
                         bus_ready0, bus_ready1, (occ < 2), occ);
            end

            if (stall) begin
                checks++;
                if (w_outs !== snap) begin
                    failures++;
                    $display("FAIL stall_stable: got %h required %h", w_outs, snap);
                end
            end
            stall = 1'b0;

            if (in_pkt) begin
                checks++;
                if (!st_valid0) begin
                    failures++;
                    $display("FAIL no_bubble: st_valid got 0 required 1 after beat %0d", cur_beat);
                end
            end

            if (fill_on) begin
                if (st_valid0 || fill_t >= 3) begin
                    checks++;
                    if (!st_valid0) begin
                        failures++;
                        $display("FAIL fill_latency: st_valid got 0 after %0d cycles, required 1 within 3", fill_t);
                    end
                    fill_on = 1'b0;
                end else begin
                    fill_t++;
                end
            end

            if (!st_valid0) gap++;

            if (st_valid0 && st_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b, required no beat",
                             st_data0, st_sop0, st_eop0);
                end else begin
                    e    = exp_q.pop_front();
                    got  = {st_data0, st_data1, st_sop0, st_eop0, st_error0,
                            st_sop1, st_eop1, st_error1, st_valid1};
                    expv = {e.lsb, e.msb, e.sop, e.eop, e.err, e.sop, e.eop, e.err, 1'b1};
                    if (got !== expv || (pat_chk && st_data0 !== ST_W'(e.idx % 4096))) begin
                        failures++;
                        $display("FAIL beat[%0d]: got %h required %h (lsb data got %h)",
                                 e.idx, got, expv, st_data0);
                    end
                    cur_beat = e.idx;
                    if (e.sop) begin
                        if (gap_chk && have_eop) begin
                            checks++;
                            if (gap > 3) begin
                                failures++;
                                $display("FAIL pkt_gap: got %0d idle cycles, required <= 3", gap);
                            end
                        end
                        in_pkt    = 1'b1;
                        first_lsb = st_data0;
                        first_msb = st_data1;
                    end
                    if (e.eop) begin
                        in_pkt   = 1'b0;
                        have_eop = 1'b1;
                        gap      = 0;
                        rel_dly  = 2;
                        if (st_error0) err_eops++;
                    end
                end
            end else if (st_valid0) begin
                stall = 1'b1;
                snap  = w_outs;
            end

            if (bus_valid && bus_ready0) begin
                words[nwords] = bus_data;
                pkt_err       = pkt_err | bus_err;
                nwords++;
                if (nwords == BUS_PER_PKT) begin
                    for (int j = 0; j < PKT_BEATS; j++) begin
                        tw    = words[j / BEATS_PER_BUS];
                        k     = j % BEATS_PER_BUS;
                        e.lsb = tw[k*ST_W +: ST_W];
                        e.msb = tw[(BEATS_PER_BUS-1-k)*ST_W +: ST_W];
                        e.sop = (j == 0);
                        e.eop = (j == PKT_BEATS - 1);
                        e.err = (j == PKT_BEATS - 1) & pkt_err;
                        e.idx = j;
                        exp_q.push_back(e);
                    end
                    nwords   = 0;
                    pkt_err  = 1'b0;
                    add_pend = 1'b1;
                end
            end
        end
    end

    task automatic drive_word(input logic [BUS_W-1:0] d, input logic e);
        int t;
        bus_data  = d;
        bus_err   = e;
        bus_valid = 1'b1;
        t = 0;
        @(negedge clk_bus);
        while (!bus_ready0 && t < 20000) begin
            @(negedge clk_bus);
            t++;
        end
        if (t >= 20000) begin
            checks++;
            failures++;
            $display("FAIL bus_accept: bus_ready got 0 for %0d cycles, required 1", t);
        end
        @(posedge clk_bus);
        #1;
    endtask

    // mode 0: beat value (w*42+k) mod 4096; 1: random; 2: mode 0 with 12'hABC in word 0 top beat.
    task automatic send_pkt(input int mode, input int err_word, input bit gaps);
        logic [BUS_W-1:0] wd;
        for (int w = 0; w < BUS_PER_PKT; w++) begin
            wd = '0;
            if (mode == 1) begin
                for (int i = 0; i < BUS_W/32; i++) wd[i*32 +: 32] = $urandom;
            end else begin
                for (int k = 0; k < BEATS_PER_BUS; k++)
                    wd[k*ST_W +: ST_W] = ST_W'((w*BEATS_PER_BUS + k) % 4096);
                wd[BUS_W-1:USED_W] = (BUS_W-USED_W)'($urandom);
                if (mode == 2 && w == 0) wd[USED_W-1 -: ST_W] = 12'hABC;
            end
            drive_word(wd, (w == err_word));
            if (gaps && $urandom_range(3) == 0) begin
                bus_valid = 1'b0;
                @(posedge clk_bus);
                #1;
            end
        end
        bus_valid = 1'b0;
        bus_err   = 1'b0;
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || occ != 0 || nwords != 0 || add_pend) && t < limit) begin
            @(posedge clk_bus);
            #1;
            t++;
        end
        checks++;
        if (t >= limit) begin
            failures++;
            $display("FAIL drain: %0d beats still pending after %0d cycles, required 0", exp_q.size(), t);
        end
        repeat (3) @(posedge clk_bus);
        #1;
    endtask

    task automatic check_cnt(input string name, input int exp_cnt);
        checks++;
        if (pkt_cnt0 !== 16'(exp_cnt) || pkt_cnt1 !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL %s: pkt_cnt got %0d/%0d required %0d", name, pkt_cnt0, pkt_cnt1, exp_cnt);
        end
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{pkts:1, ready_pct:100, mode:0, err_pkt:-1, err_word:0,  bus_gaps:0, gap_chk:0, exp_pkt_cnt:1,  exp_err_eops:0};
        vecs[1] = '{pkts:3, ready_pct:100, mode:0, err_pkt:-1, err_word:0,  bus_gaps:0, gap_chk:1, exp_pkt_cnt:4,  exp_err_eops:0};
        vecs[2] = '{pkts:2, ready_pct:50,  mode:1, err_pkt:-1, err_word:0,  bus_gaps:1, gap_chk:0, exp_pkt_cnt:6,  exp_err_eops:0};
        vecs[3] = '{pkts:3, ready_pct:100, mode:1, err_pkt:1,  err_word:7,  bus_gaps:0, gap_chk:1, exp_pkt_cnt:9,  exp_err_eops:1};
        vecs[4] = '{pkts:2, ready_pct:70,  mode:1, err_pkt:0,  err_word:0,  bus_gaps:0, gap_chk:0, exp_pkt_cnt:11, exp_err_eops:1};
        vecs[5] = '{pkts:1, ready_pct:30,  mode:1, err_pkt:0,  err_word:24, bus_gaps:1, gap_chk:0, exp_pkt_cnt:12, exp_err_eops:1};

        rst_n     = 1'b0;
        bus_valid = 1'b0;
        bus_err   = 1'b0;
        bus_data  = '0;
        repeat (3) @(posedge clk_bus);
        #1;
        checks++;
        if (bus_ready0 !== 1'b0 || st_valid0 !== 1'b0 || st_data0 !== '0 || pkt_cnt0 !== '0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b valid=%b data=%h cnt=%0d, required 0",
                     bus_ready0, st_valid0, st_data0, pkt_cnt0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: bus_ready got %b required 1", bus_ready0);
        end

        for (int i = 0; i < 6; i++) begin
            ready_pct = vecs[i].ready_pct;
            gap_chk   = vecs[i].gap_chk;
            pat_chk   = (vecs[i].mode == 0);
            have_eop  = 1'b0;
            begin
                int base;
                base = err_eops;
                for (int p = 0; p < vecs[i].pkts; p++)
                    send_pkt(vecs[i].mode, (p == vecs[i].err_pkt) ? vecs[i].err_word : -1,
                             vecs[i].bus_gaps);
                drain(vecs[i].pkts * 8000);
                check_cnt($sformatf("vec%0d_pkt_cnt", i), vecs[i].exp_pkt_cnt);
                checks++;
                if (err_eops - base != vecs[i].exp_err_eops) begin
                    failures++;
                    $display("FAIL vec%0d_err_eops: got %0d required %0d", i, err_eops - base,
                             vecs[i].exp_err_eops);
                end
            end
        end

        // Reset in the middle of a packet, with the other buffer already full.
        ready_pct = 100;
        gap_chk   = 1'b0;
        pat_chk   = 1'b0;
        cur_beat  = -1;
        send_pkt(1, -1, 1'b0);
        send_pkt(1, -1, 1'b0);
        begin
            int t;
            t = 0;
            while (cur_beat < 500 && t < 5000) begin
                @(posedge clk_bus);
                #1;
                t++;
            end
            checks++;
            if (t >= 5000) begin
                failures++;
                $display("FAIL reach_beat_500: got beat %0d required 500", cur_beat);
            end
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk_bus);
        #1;
        check_cnt("pkt_cnt_in_reset", 0);
        rst_n = 1'b1;
        repeat (40) @(posedge clk_bus);
        #1;
        checks++;
        if (st_valid0 !== 1'b0 || bus_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle: got valid=%b ready=%b required valid=0 ready=1",
                     st_valid0, bus_ready0);
        end
        send_pkt(2, -1, 1'b0);
        drain(8000);
        check_cnt("pkt_cnt_after_reset", 1);
        checks++;
        if (first_msb !== 12'hABC || first_lsb !== 12'h000) begin
            failures++;
            $display("FAIL first_beat: got msb=%h lsb=%h required msb=abc lsb=000", first_msb, first_lsb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
